// File: rtl/fso_pkg.sv
// Shared constants for the FSO TX datapath.
//   WORD_W          payload word width
//   CRC32_POLY      CRC-32 generator polynomial (MSB-first form)
//   CRC32_INIT      CRC register value at the start of a frame
//   PRBS15_SEED     PRBS15 LFSR state at the start of a frame
//   FRAME_PREAMBLE* framer preamble words (used by the framer, not here)
package fso_pkg;
  localparam int          WORD_W          = 32;
  localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [14:0] PRBS15_SEED     = 15'h7FFF;
  localparam logic [31:0] FRAME_PREAMBLE0 = 32'hEB94BDA3;
  localparam logic [31:0] FRAME_PREAMBLE1 = 32'hF6AAEE24;
endpackage

// File: rtl/crc32_scrambler_if.sv
// Framer <-> payload-protection bus.
//   frame_rst  per-frame reinitialise pulse (framer drives)
//   data_in    unscrambled payload word (framer drives)
//   scram_en   advance keystream by one word (framer drives)
//   crc_en     fold data_in into the CRC (framer drives)
//   scram_out  data_in XOR current keystream word (block drives)
//   crc_out    CRC register contents (block drives)
interface crc32_scrambler_if;
  import fso_pkg::*;

  logic              frame_rst;
  logic [WORD_W-1:0] data_in;
  logic              scram_en;
  logic              crc_en;
  logic [WORD_W-1:0] scram_out;
  logic [WORD_W-1:0] crc_out;

  modport master (
    output frame_rst, data_in, scram_en, crc_en,
    input  scram_out, crc_out
  );

  modport slave (
    input  frame_rst, data_in, scram_en, crc_en,
    output scram_out, crc_out
  );
endinterface

// File: rtl/prbs15_keystream.sv
// PRBS15 (x^15+x^14+1) Fibonacci LFSR producing one 32-bit keystream word
// per enable.
//   clk          rising-edge clock
//   rst          synchronous active-high reset, loads SCRAM_SEED
//   i_load       per-frame reload of SCRAM_SEED
//   i_adv        advance the state by 32 steps
//   o_keystream  keystream word of the current state (first bit -> bit 31)
module prbs15_keystream
  import fso_pkg::*;
#(
  parameter logic [14:0] SCRAM_SEED = PRBS15_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_adv,
  output logic [WORD_W-1:0] o_keystream
);

  logic [14:0]       r_state;
  logic [14:0]       w_state_next;
  logic [WORD_W-1:0] w_keystream;

  // Unrolled 32 LFSR steps. Each new bit is shifted in at the LSB of the
  // keystream, so the first generated bit ends up in bit 31.
  function automatic logic [14+WORD_W:0] prbs15_step32(input logic [14:0] s);
    logic [14:0]       st;
    logic [WORD_W-1:0] ks;
    logic              b;
    st = s;
    ks = '0;
    for (int i = 0; i < WORD_W; i++) begin
      b  = st[14] ^ st[13];
      ks = {ks[WORD_W-2:0], b};
      st = {st[13:0], b};
    end
    return {st, ks};
  endfunction

  assign {w_state_next, w_keystream} = prbs15_step32(r_state);
  assign o_keystream = w_keystream;

  // State register: reset and frame reload both override an advance.
  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_state <= SCRAM_SEED;
    end else if (i_adv) begin
      r_state <= w_state_next;
    end
  end

endmodule

// File: rtl/crc32_scrambler.sv
// Per-frame payload protection: additive PRBS15 scrambler plus word-parallel
// CRC-32 (poly 0x04C11DB7, MSB-first, no reflection, no final XOR) computed
// over the unscrambled payload.
//   clk  rising-edge clock
//   rst  synchronous active-high reset (LFSR <- SCRAM_SEED, CRC <- CRC_INIT)
//   bus  slave side of crc32_scrambler_if:
//        frame_rst/data_in/scram_en/crc_en in, scram_out/crc_out out.
//        scram_out is combinational; crc_out is registered.
module crc32_scrambler
  import fso_pkg::*;
#(
  parameter logic [14:0] SCRAM_SEED = PRBS15_SEED,
  parameter logic [31:0] CRC_INIT   = CRC32_INIT
) (
  input  logic               clk,
  input  logic               rst,
  crc32_scrambler_if.slave   bus
);

  logic [WORD_W-1:0] w_keystream;
  logic [WORD_W-1:0] w_crc_next;
  logic [WORD_W-1:0] r_crc;

  // With a 32-bit word and a 32-bit register, the whole data word can be
  // folded into the register up front and then divided for 32 shifts; this
  // is identical to 32 serial steps with data_in[31] first.
  function automatic logic [WORD_W-1:0] crc32_step32(
    input logic [WORD_W-1:0] c,
    input logic [WORD_W-1:0] d
  );
    logic [WORD_W-1:0] r;
    r = c ^ d;
    for (int i = 0; i < WORD_W; i++) begin
      if (r[WORD_W-1]) r = {r[WORD_W-2:0], 1'b0} ^ CRC32_POLY;
      else             r = {r[WORD_W-2:0], 1'b0};
    end
    return r;
  endfunction

  prbs15_keystream #(
    .SCRAM_SEED (SCRAM_SEED)
  ) u_prbs (
    .clk         (clk),
    .rst         (rst),
    .i_load      (bus.frame_rst),
    .i_adv       (bus.scram_en),
    .o_keystream (w_keystream)
  );

  assign w_crc_next    = crc32_step32(r_crc, bus.data_in);
  assign bus.scram_out = bus.data_in ^ w_keystream;
  assign bus.crc_out   = r_crc;

  // CRC register: rst > frame_rst > crc_en; holds otherwise.
  always_ff @(posedge clk) begin
    if (rst || bus.frame_rst) begin
      r_crc <= CRC_INIT;
    end else if (bus.crc_en) begin
      r_crc <= w_crc_next;
    end
  end

endmodule

// File: tb/tb_crc32_scrambler.sv
module tb_crc32_scrambler;
  import fso_pkg::*;

  localparam logic [14:0] SEED = 15'h7FFF;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc32_scrambler_if if0 ();
  crc32_scrambler_if if1 ();

  // Second instance descrambles the first one's output with aligned control.
  assign if1.data_in   = if0.scram_out;
  assign if1.scram_en  = if0.scram_en;
  assign if1.frame_rst = if0.frame_rst;
  assign if1.crc_en    = 1'b0;

  crc32_scrambler #(.SCRAM_SEED(SEED), .CRC_INIT(INIT)) dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  crc32_scrambler #(.SCRAM_SEED(SEED), .CRC_INIT(INIT)) dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  int checks = 0;
  int errors = 0;

  // Reference keystream: PRBS sequence a[n] = a[n-15] ^ a[n-14] seeded with
  // a[0..14] = SEED[14..0]; word w uses bits a[15+32w .. 15+32w+31].
  function automatic logic [31:0] model_ks(input int w);
    bit          a [0:2200];
    logic [31:0] ks;
    for (int i = 0; i < 15; i++) a[i] = SEED[14-i];
    for (int n = 15; n < 15 + 32*(w+1); n++) a[n] = a[n-15] ^ a[n-14];
    ks = '0;
    for (int k = 0; k < 32; k++) ks[31-k] = a[15 + 32*w + k];
    return ks;
  endfunction

  // Reference CRC: bit-serial, data MSB first.
  function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [31:0] d);
    logic fb;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if0.frame_rst = 1'b0;
    if0.scram_en  = 1'b0;
    if0.crc_en    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    if0.data_in = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (if0.scram_out !== 32'h0002000C) begin
        errors++;
        $display("FAIL reset_scram cyc=%0d got=%h exp=%h", i, if0.scram_out, 32'h0002000C);
      end
      checks++;
      if (if0.crc_out !== INIT) begin
        errors++;
        $display("FAIL reset_crc cyc=%0d got=%h exp=%h", i, if0.crc_out, INIT);
      end
    end
  endtask

  task automatic test_crc_vectors();
    if0.frame_rst = 1'b1;
    step();
    idle();
    if0.crc_en  = 1'b1;
    if0.data_in = 32'hFFFFFFFF;
    step();
    checks++;
    if (if0.crc_out !== 32'h0) begin
      errors++;
      $display("FAIL crc_ones got=%h exp=%h", if0.crc_out, 32'h0);
    end
    if0.data_in = 32'h00000001;
    step();
    checks++;
    if (if0.crc_out !== 32'h04C11DB7) begin
      errors++;
      $display("FAIL crc_one got=%h exp=%h", if0.crc_out, 32'h04C11DB7);
    end
    idle();
    if0.data_in = 32'h0;
    step();
    checks++;
    if (if0.crc_out !== 32'h04C11DB7) begin
      errors++;
      $display("FAIL crc_hold got=%h exp=%h", if0.crc_out, 32'h04C11DB7);
    end
    // CRC advanced with scrambling bypassed: keystream still at seed.
    checks++;
    if (if0.scram_out !== 32'h0002000C) begin
      errors++;
      $display("FAIL scram_bypass got=%h exp=%h", if0.scram_out, 32'h0002000C);
    end
  endtask

  task automatic test_descramble();
    logic [31:0] d;
    if0.frame_rst = 1'b1;
    step();
    idle();
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      if0.data_in  = d;
      if0.scram_en = 1'b1;
      #1;
      checks++;
      if (if0.scram_out !== (d ^ model_ks(w))) begin
        errors++;
        $display("FAIL scramble w=%0d got=%h exp=%h", w, if0.scram_out, d ^ model_ks(w));
      end
      checks++;
      if (if1.scram_out !== d) begin
        errors++;
        $display("FAIL descramble w=%0d got=%h exp=%h", w, if1.scram_out, d);
      end
      checks++;
      if ((if0.scram_out ^ d) === 32'h0) begin
        errors++;
        $display("FAIL ks_nonzero w=%0d got=%h exp=nonzero", w, if0.scram_out ^ d);
      end
      step();
    end
    idle();
  endtask

  task automatic test_frame_rst_collision();
    logic [31:0] c;
    logic [31:0] d;
    if0.frame_rst = 1'b1;
    step();
    idle();
    c = INIT;
    for (int w = 0; w < 5; w++) begin
      d = $urandom;
      if0.data_in  = d;
      if0.crc_en   = 1'b1;
      if0.scram_en = 1'b1;
      step();
      c = model_crc(c, d);
    end
    idle();
    checks++;
    if (if0.crc_out !== c) begin
      errors++;
      $display("FAIL midframe_crc got=%h exp=%h", if0.crc_out, c);
    end
    if0.frame_rst = 1'b1;
    if0.crc_en    = 1'b1;
    if0.scram_en  = 1'b1;
    if0.data_in   = $urandom;
    step();
    idle();
    if0.data_in = 32'h0;
    #1;
    checks++;
    if (if0.crc_out !== INIT) begin
      errors++;
      $display("FAIL frst_crc got=%h exp=%h", if0.crc_out, INIT);
    end
    checks++;
    if (if0.scram_out !== 32'h0002000C) begin
      errors++;
      $display("FAIL frst_scram got=%h exp=%h", if0.scram_out, 32'h0002000C);
    end
  endtask

  task automatic test_throttle();
    logic [31:0] c;
    logic [31:0] d;
    int          w;
    int          cyc;
    if0.frame_rst = 1'b1;
    step();
    idle();
    c   = INIT;
    w   = 0;
    cyc = 0;
    while (w < 16 && cyc < 200) begin
      cyc++;
      if ($urandom_range(0, 2) == 0) begin
        idle();
        if0.data_in = $urandom;
        #1;
        checks++;
        if (if0.crc_out !== c) begin
          errors++;
          $display("FAIL gap_hold w=%0d got=%h exp=%h", w, if0.crc_out, c);
        end
        step();
      end else begin
        d = $urandom;
        if0.data_in  = d;
        if0.crc_en   = 1'b1;
        if0.scram_en = 1'b1;
        #1;
        checks++;
        if (if0.scram_out !== (d ^ model_ks(w))) begin
          errors++;
          $display("FAIL thr_scram w=%0d got=%h exp=%h", w, if0.scram_out, d ^ model_ks(w));
        end
        step();
        c = model_crc(c, d);
        w++;
      end
    end
    idle();
    checks++;
    if (w != 16) begin
      errors++;
      $display("FAIL thr_timeout got=%0d exp=16", w);
    end
    checks++;
    if (if0.crc_out !== c) begin
      errors++;
      $display("FAIL thr_crc got=%h exp=%h", if0.crc_out, c);
    end
  endtask

  task automatic test_rst_midframe();
    logic [31:0] words [16];
    logic [31:0] sc    [16];
    logic [31:0] c;
    logic [31:0] crc_clean;
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    // Clean reference run.
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    c = INIT;
    for (int w = 0; w < 16; w++) begin
      if0.data_in  = words[w];
      if0.crc_en   = 1'b1;
      if0.scram_en = 1'b1;
      #1;
      sc[w] = if0.scram_out;
      checks++;
      if (sc[w] !== (words[w] ^ model_ks(w))) begin
        errors++;
        $display("FAIL clean_scram w=%0d got=%h exp=%h", w, sc[w], words[w] ^ model_ks(w));
      end
      step();
      c = model_crc(c, words[w]);
    end
    idle();
    crc_clean = if0.crc_out;
    checks++;
    if (crc_clean !== c) begin
      errors++;
      $display("FAIL clean_crc got=%h exp=%h", crc_clean, c);
    end
    // Partial frame, then reset with enables still high.
    if0.frame_rst = 1'b1;
    step();
    idle();
    for (int w = 0; w < 7; w++) begin
      if0.data_in  = $urandom;
      if0.crc_en   = 1'b1;
      if0.scram_en = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    for (int w = 0; w < 16; w++) begin
      if0.data_in  = words[w];
      if0.crc_en   = 1'b1;
      if0.scram_en = 1'b1;
      #1;
      checks++;
      if (if0.scram_out !== sc[w]) begin
        errors++;
        $display("FAIL rerun_scram w=%0d got=%h exp=%h", w, if0.scram_out, sc[w]);
      end
      step();
    end
    idle();
    checks++;
    if (if0.crc_out !== crc_clean) begin
      errors++;
      $display("FAIL rerun_crc got=%h exp=%h", if0.crc_out, crc_clean);
    end
  endtask

  initial begin
    rst         = 1'b1;
    if0.data_in = '0;
    idle();
    test_reset();
    test_crc_vectors();
    test_descramble();
    test_frame_rst_collision();
    test_throttle();
    test_rst_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
